writeback_stage: RTL
====================

# writeback_stage

Final (WB) stage of the five-stage RISC-V pipeline, directly downstream of `mem_stage`. It holds the MEM/WB pipeline register. It formats load data according to `funct3` and the byte offset, and selects the register-file write-back source. It drives the register-file write port and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- `INSTRET_WIDTH`, default 64, width of the retired-instruction counter.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset_n`  input  1  reset; one clock, asynchronous, active-low.
- `stall_in`  input  1  hold the MEM/WB register contents.
- `flush_in`  input  1  load a bubble into the MEM/WB register; has priority over `stall_in`.
- `valid_in`  input  1  MEM-stage slot holds a real instruction.
- `alu_data_in`  input  32  `alu_data_out` of `mem_stage` (result or byte address).
- `memory_data_in`  input  32  `memory_data_out` of `mem_stage`. This is the word-aligned 32-bit read word, combinational in the MEM cycle.
- `pc_plus4_in`  input  32  return address for JAL/JALR.
- `rd_in`  input  5  destination register.
- `control_in`  input  `control_type`  `control_out` of `mem_stage`.
- `rf_write_enable`  output  1  register-file write strobe.
- `rf_write_address`  output  5  register-file write index.
- `rf_write_data`  output  32  register-file write data; also the forwarding source.
- `load_fault_out`  output  1  the WB entry is a misaligned or illegal load.
- `instret_out`  output  `INSTRET_WIDTH`  retired-instruction count.

## Operation
- MEM/WB register fields: `valid_q`, `alu_q`, `mem_q`, `pc4_q`, `rd_q`, `ctrl_q`.
- The register advances when `advance = ~stall_in | flush_in`.
- On each edge:
  - `flush_in` = 1: `valid_q` ← 0 and `ctrl_q` ← all-zero. The data fields are don't-care and are loaded with 0.
  - Else if `stall_in` = 0: all fields ← their inputs.
  - Else (stalled): all fields hold.
- Load formatting uses `off = alu_q[1:0]`, with `ctrl_q.funct3` selecting the operation:
  - 000 LB: sign-extend the byte `mem_q[8*off +: 8]`.
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend the halfword `mem_q[16*off[1] +: 16]`.
  - 101 LHU: zero-extend the same halfword.
  - 010 LW: `mem_q`.
- `load_fault` = `valid_q & ctrl_q.mem_read` and any of the following:
  - `funct3` ∈ {011, 110, 111};
  - LH/LHU with `off[0]` = 1;
  - LW with `off` ≠ 0.
- On a fault the formatted data is 0.
- Write-back select, by `ctrl_q.wb_sel`:
  - WB_ALU → `alu_q`
  - WB_MEM → formatted load
  - WB_PC4 → `pc4_q`
- Register-file outputs:
  - `rf_write_enable = valid_q & ctrl_q.reg_write & (rd_q != 0) & ~load_fault`.
  - `rf_write_address = rd_q`.
- Writes to x0 are never issued.
- During a stall, the same write is presented every cycle. This is idempotent and intended.
- Retire: on an edge with `valid_q & advance & ~load_fault`, `instret` increments by 1 and wraps modulo 2^`INSTRET_WIDTH`. A stalled entry is therefore counted exactly once.
- When flush and stall are asserted together, the current WB entry still retires and a bubble enters.

## Timing
- Latency: MEM-cycle inputs appear on the `rf_*` outputs one cycle later.
- All outputs are combinational from registered state; there is no input-to-output combinational path.
- Reset (asynchronous assert, release on the clock) drives:
  - all MEM/WB fields to 0 and `valid_q` = 0;
  - `rf_write_enable` = 0, `rf_write_address` = 0, `rf_write_data` = 0;
  - `load_fault_out` = 0, `instret_out` = 0.
- Reset mid-stall discards the held entry, and that entry is not counted.
- The first edge after reset release with valid input loads it; its write appears in the following cycle.
- The register file writes on the rising edge. A register written in WB and read in ID in the same cycle is resolved by the register file (write-before-read) or by forwarding `rf_write_data`; that resolution is outside this block.

## Structure
- `riscv_pkg` (shared) holds:
  - `control_type` with fields `reg_write`, `mem_read`, `mem_write`, `wb_sel`, `funct3[2:0]`;
  - enum `wb_sel_type` {WB_ALU = 0, WB_MEM = 1, WB_PC4 = 2};
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- One sub-module, `load_formatter`, is purely combinational.
  - Inputs: `funct3`, `off`, `mem_q`.
  - Outputs: formatted data, `fault`.
- The pipeline register and the counter stay in `writeback_stage`.

## Test plan
- LB sign-extend and LBU zero-extend:
  - LB with `memory_data_in` = 0x80FF_7F01 and `alu_data_in` = 0x103 gives `rf_write_data` = 0xFFFF_FF80 on the next cycle, with `rf_write_enable` = 1.
  - The same input as LBU gives 0x0000_0080.
- LH at offset 2 with word 0x8001_1234 gives 0xFFFF_8001. LH at offset 1 gives `load_fault_out` = 1 and `rf_write_enable` = 0, and `instret_out` does not increment.
- Write to x0: ALU op with `rd_in` = 0 and `alu_data_in` = 5 gives `rf_write_enable` = 0, while `instret_out` still increments by 1.
- Stall hold: hold `stall_in` = 1 for 3 cycles with a WB_PC4 entry (`pc_plus4_in` = 0x44). `rf_write_data` stays 0x44 for 4 cycles, and `instret_out` rises by exactly 1, after the stall releases.
- Flush with stall: `flush_in` = `stall_in` = 1 on a valid WB entry. The entry retires (+1), and the next cycle shows `rf_write_enable` = 0 and `valid_q` = 0.
- Asynchronous reset: assert `reset_n` = 0 mid-cycle while the counter reads 7. All outputs go to 0 immediately, without waiting for a clock edge, and stay 0 until the first valid entry after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: the control bundle carried down to WB,
// write-back source encoding and load funct3 codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_type;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    wb_sel_type wb_sel;
    logic [2:0] funct3;
  } control_type;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword of the aligned read word;
// flags unsupported funct3 codes and misaligned accesses.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] mem_q,
  output logic [31:0] data_out,
  output logic        fault_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = mem_q[7:0];
      2'd1:    byte_sel = mem_q[15:8];
      2'd2:    byte_sel = mem_q[23:16];
      default: byte_sel = mem_q[31:24];
    endcase
    half_sel = off[1] ? mem_q[31:16] : mem_q[15:0];
  end

  // A faulting access returns 0 so nothing stale leaks onto the write bus.
  always_comb begin
    data_out  = '0;
    fault_out = 1'b0;
    case (funct3)
      F3_LB:  data_out = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data_out = {24'd0, byte_sel};
      F3_LH: begin
        if (off[0]) fault_out = 1'b1;
        else        data_out  = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (off[0]) fault_out = 1'b1;
        else        data_out  = {16'd0, half_sel};
      end
      F3_LW: begin
        if (off != 2'd0) fault_out = 1'b1;
        else             data_out  = mem_q;
      end
      default: fault_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// WB stage: MEM/WB register, load formatting, write-back mux, register-file
// write port and retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall_in,
  input  logic                     flush_in,
  input  logic                     valid_in,
  input  logic [31:0]              alu_data_in,
  input  logic [31:0]              memory_data_in,
  input  logic [31:0]              pc_plus4_in,
  input  logic [4:0]               rd_in,
  input  control_type              control_in,
  output logic                     rf_write_enable,
  output logic [4:0]               rf_write_address,
  output logic [31:0]              rf_write_data,
  output logic                     load_fault_out,
  output logic [INSTRET_WIDTH-1:0] instret_out
);

  logic                     valid_q, valid_d;
  logic [31:0]              alu_q, alu_d;
  logic [31:0]              mem_q, mem_d;
  logic [31:0]              pc4_q, pc4_d;
  logic [4:0]               rd_q, rd_d;
  control_type              ctrl_q, ctrl_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic        advance;
  logic [31:0] load_data;
  logic        fmt_fault;
  logic        load_fault;
  logic [31:0] wb_data;

  load_formatter u_load_formatter (
    .funct3    (ctrl_q.funct3),
    .off       (alu_q[1:0]),
    .mem_q     (mem_q),
    .data_out  (load_data),
    .fault_out (fmt_fault)
  );

  assign advance    = ~stall_in | flush_in;
  assign load_fault = valid_q & ctrl_q.mem_read & fmt_fault;

  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush_in) begin
      valid_d = 1'b0;
      alu_d   = '0;
      mem_d   = '0;
      pc4_d   = '0;
      rd_d    = '0;
      ctrl_d  = '0;
    end else if (!stall_in) begin
      valid_d = valid_in;
      alu_d   = alu_data_in;
      mem_d   = memory_data_in;
      pc4_d   = pc_plus4_in;
      rd_d    = rd_in;
      ctrl_d  = control_in;
    end
  end

  // The entry retires on the edge that moves it out, so a stalled entry counts once.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && advance && !load_fault)
      instret_d = instret_q + INSTRET_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      alu_q     <= '0;
      mem_q     <= '0;
      pc4_q     <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      pc4_q     <= pc4_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    case (ctrl_q.wb_sel)
      WB_ALU:  wb_data = alu_q;
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc4_q;
      default: wb_data = '0;
    endcase
  end

  assign rf_write_enable  = valid_q & ctrl_q.reg_write & (rd_q != 5'd0) & ~load_fault;
  assign rf_write_address = rd_q;
  assign rf_write_data    = wb_data;
  assign load_fault_out   = load_fault;
  assign instret_out      = instret_q;

endmodule
